// File: rtl/imm_ext_stage.sv
// LEGv8 decode immediate stage: classifies the immediate format, extends it to 64 bits and forms PC-relative targets.
// One cycle from accept to out_valid through a 2-entry elastic buffer; in_ready drops only when both entries are held.

module fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wr_dat,
   output logic [W-1:0] rd_dat,
   output logic         full,
   output logic         empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_dat  = mem[rd_ptr];

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_next(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: readers gate rd_dat with !empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_dat;
   end

endmodule

module imm_ext_stage #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic [63:0]      pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      imm,
   output logic [2:0]       imm_type,
   output logic [63:0]      br_target,
   output logic [63:0]      pc_out,
   output logic [CNT_W-1:0] unk_cnt
);

   typedef enum logic [2:0] {
      T_NONE   = 3'd0,
      T_I12_ZE = 3'd1,
      T_D9_SE  = 3'd2,
      T_B26    = 3'd3,
      T_CB19   = 3'd4,
      T_SHAMT  = 3'd5
   } imm_type_t;

   typedef struct packed {
      logic [63:0] pc;
      logic [63:0] br_target;
      imm_type_t   imm_type;
      logic [63:0] imm;
   } entry_t;

   entry_t    dec;
   entry_t    head;
   imm_type_t dec_type;
   logic [63:0] dec_imm;
   logic      full;
   logic      empty;
   logic      push;
   logic      pop;

   always_comb begin
      dec_type = T_NONE;
      dec_imm  = '0;
      if (instr[31:22] == 10'b1001000100 || instr[31:22] == 10'b1101000100) begin
         dec_type = T_I12_ZE;
         dec_imm  = {52'b0, instr[21:10]};
      end else if (instr[31:21] == 11'b11111000010 || instr[31:21] == 11'b11111000000) begin
         dec_type = T_D9_SE;
         dec_imm  = {{55{instr[20]}}, instr[20:12]};
      end else if (instr[31:26] == 6'b000101 || instr[31:26] == 6'b100101) begin
         dec_type = T_B26;
         dec_imm  = {{36{instr[25]}}, instr[25:0], 2'b00};
      end else if (instr[31:24] == 8'b10110100 || instr[31:24] == 8'b10110101 ||
                   instr[31:24] == 8'b01010100) begin
         dec_type = T_CB19;
         dec_imm  = {{43{instr[23]}}, instr[23:5], 2'b00};
      end else if (instr[31:21] == 11'b11010011011 || instr[31:21] == 11'b11010011010) begin
         dec_type = T_SHAMT;
         dec_imm  = {58'b0, instr[15:10]};
      end
   end

   always_comb begin
      dec.pc        = pc;
      dec.imm_type  = dec_type;
      dec.imm       = dec_imm;
      dec.br_target = (dec_type == T_B26 || dec_type == T_CB19) ? pc + dec_imm : 64'd0;
   end

   // Handshake uses only registered buffer state, so in_ready never waits on out_ready.
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   fifo #(
      .W     ($bits(entry_t)),
      .DEPTH (DEPTH)
   ) u_buf (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .wr_dat  (dec),
      .rd_dat  (head),
      .full    (full),
      .empty   (empty)
   );

   assign imm       = out_valid ? head.imm       : 64'd0;
   assign imm_type  = out_valid ? head.imm_type  : T_NONE;
   assign br_target = out_valid ? head.br_target : 64'd0;
   assign pc_out    = out_valid ? head.pc        : 64'd0;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         unk_cnt <= '0;
      end else if (push && dec_type == T_NONE && unk_cnt != '1) begin
         unk_cnt <= unk_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_imm_ext_stage.sv
// Directed bench for imm_ext_stage: decode vector table plus backpressure, saturation and reset sequences.
module tb_imm_ext_stage;

   localparam int CNT_W = 10;
   localparam int NV    = 13;
   localparam logic [31:0] NONE_I = 32'h8B020020;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      instr;
   logic [63:0]      pc;
   logic             out_valid;
   logic             out_ready;
   logic [63:0]      imm;
   logic [2:0]       imm_type;
   logic [63:0]      br_target;
   logic [63:0]      pc_out;
   logic [CNT_W-1:0] unk_cnt;

   int total = 0;
   int bad   = 0;
   int exp_unk = 0;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc;
      logic [2:0]  typ;
      logic [63:0] imm;
      logic [63:0] tgt;
   } vec_t;

   vec_t v [NV];

   imm_ext_stage #(.DEPTH(2), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .pc        (pc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .imm       (imm),
      .imm_type  (imm_type),
      .br_target (br_target),
      .pc_out    (pc_out),
      .unk_cnt   (unk_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic int sat_inc(input int c, input int n);
      int r;
      r = c + n;
      return (r > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : r;
   endfunction

   task automatic chk_idle(input string name);
      chk({name, ".out_valid"}, 64'(out_valid), 64'd0);
      chk({name, ".imm"}, imm, 64'd0);
      chk({name, ".imm_type"}, 64'(imm_type), 64'd0);
      chk({name, ".br_target"}, br_target, 64'd0);
      chk({name, ".pc_out"}, pc_out, 64'd0);
      chk({name, ".in_ready"}, 64'(in_ready), 64'd1);
   endtask

   function automatic logic [31:0] addi(input logic [11:0] k);
      return {10'b1001000100, k, 10'd0};
   endfunction

   initial begin
      v[0]  = '{32'h913FF041, 64'h100, 3'd1, 64'h0000000000000FFC, 64'h0};
      v[1]  = '{{11'b11111000010, 9'h1F0, 2'b00, 5'd1, 5'd2}, 64'h200, 3'd2, 64'hFFFFFFFFFFFFFFF0, 64'h0};
      v[2]  = '{{6'b000101, 26'h3FFFFFF}, 64'h40, 3'd3, 64'hFFFFFFFFFFFFFFFC, 64'h3C};
      v[3]  = '{{8'b10110100, 19'h00003, 5'd0}, 64'hFFFFFFFFFFFFFFF8, 3'd4, 64'hC, 64'h4};
      v[4]  = '{{11'b11111000000, 9'h0FF, 12'h000}, 64'h300, 3'd2, 64'hFF, 64'h0};
      v[5]  = '{{10'b1101000100, 12'h001, 10'h0}, 64'h304, 3'd1, 64'h1, 64'h0};
      v[6]  = '{{6'b100101, 26'h0000010}, 64'h1000, 3'd3, 64'h40, 64'h1040};
      v[7]  = '{{8'b01010100, 19'h7FFFF, 5'h0}, 64'h100, 3'd4, 64'hFFFFFFFFFFFFFFFC, 64'hFC};
      v[8]  = '{{8'b10110101, 19'h40000, 5'd3}, 64'h200000, 3'd4, 64'hFFFFFFFFFFF00000, 64'h100000};
      v[9]  = '{{11'b11010011011, 5'd1, 6'd63, 5'd2, 5'd3}, 64'h8, 3'd5, 64'h3F, 64'h0};
      v[10] = '{{11'b11010011010, 5'd0, 6'd5, 10'd0}, 64'hC, 3'd5, 64'h5, 64'h0};
      v[11] = '{NONE_I, 64'h10, 3'd0, 64'h0, 64'h0};
      v[12] = '{32'hFFFFFFFF, 64'h14, 3'd0, 64'h0, 64'h0};

      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; instr = '0; pc = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_idle("reset");
      chk("reset.unk_cnt", 64'(unk_cnt), 64'd0);
      reset_n = 1'b1;

      // Decode table: one instruction per push, checked the cycle after acceptance.
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         in_valid = 1'b1; instr = v[i].instr; pc = v[i].pc;
         @(negedge clk);
         in_valid = 1'b0;
         if (v[i].typ == 3'd0) exp_unk = sat_inc(exp_unk, 1);
         chk($sformatf("v%0d.out_valid", i), 64'(out_valid), 64'd1);
         chk($sformatf("v%0d.imm_type", i), 64'(imm_type), 64'(v[i].typ));
         chk($sformatf("v%0d.imm", i), imm, v[i].imm);
         chk($sformatf("v%0d.br_target", i), br_target, v[i].tgt);
         chk($sformatf("v%0d.pc_out", i), pc_out, v[i].pc);
      end
      @(negedge clk);
      chk_idle("drained");
      chk("table.unk_cnt", 64'(unk_cnt), 64'(exp_unk));

      // Backpressure: fill both slots, third offer held off until the first pop.
      out_ready = 1'b0;
      in_valid = 1'b1; instr = addi(12'd1); pc = 64'h10;
      chk("bp.rdy0", 64'(in_ready), 64'd1);
      @(negedge clk);
      chk("bp.rdy1", 64'(in_ready), 64'd1);
      instr = addi(12'd2); pc = 64'h20;
      @(negedge clk);
      chk("bp.full_rdy", 64'(in_ready), 64'd0);
      instr = NONE_I; pc = 64'h30;
      @(negedge clk);
      chk("bp.still_full", 64'(in_ready), 64'd0);
      chk("bp.hold_imm", imm, 64'd1);
      chk("bp.hold_pc", pc_out, 64'h10);
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp.rdy_after_pop", 64'(in_ready), 64'd1);
      chk("bp.head2_imm", imm, 64'd2);
      chk("bp.head2_pc", pc_out, 64'h20);
      @(negedge clk);
      in_valid = 1'b0;
      exp_unk = sat_inc(exp_unk, 1);
      chk("bp.head3_valid", 64'(out_valid), 64'd1);
      chk("bp.head3_type", 64'(imm_type), 64'd0);
      chk("bp.head3_pc", pc_out, 64'h30);
      chk("bp.unk_once", 64'(unk_cnt), 64'(exp_unk));
      @(negedge clk);
      chk_idle("bp.drained");

      // Saturation: stream NONE instructions, first up to just below all-ones, then past it.
      in_valid = 1'b1; instr = NONE_I; pc = 64'h40;
      repeat ((1 << CNT_W) - 4 - exp_unk) @(negedge clk);
      exp_unk = (1 << CNT_W) - 4;
      chk("sat.below", 64'(unk_cnt), 64'(exp_unk));
      repeat (32) @(negedge clk);
      exp_unk = sat_inc(exp_unk, 32);
      chk("sat.hold", 64'(unk_cnt), 64'(exp_unk));
      in_valid = 1'b0;
      @(negedge clk);

      // Reset with both slots full, in_valid held high through reset.
      out_ready = 1'b0; in_valid = 1'b1; instr = addi(12'd7); pc = 64'h50;
      repeat (2) @(negedge clk);
      chk("rst.pre_full", 64'(in_ready), 64'd0);
      chk("rst.pre_valid", 64'(out_valid), 64'd1);
      reset_n = 1'b0; instr = NONE_I;
      @(negedge clk);
      chk("rst.valid", 64'(out_valid), 64'd0);
      chk("rst.unk", 64'(unk_cnt), 64'd0);
      chk("rst.rdy", 64'(in_ready), 64'd1);
      @(negedge clk);
      chk("rst.hold_valid", 64'(out_valid), 64'd0);
      chk("rst.hold_unk", 64'(unk_cnt), 64'd0);
      reset_n = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      chk_idle("rst.after");
      chk("rst.after_unk", 64'(unk_cnt), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
